// File: rtl/clk_div_monitor_pkg.sv
// clk_div_monitor_pkg: shared types and helpers for the divided-clock monitor.
//   mon_state_e : measurement state (IDLE waits for the first rise, MEASURE counts periods)
//   cnt_width() : counter/period width able to hold MAX_RATIO+1 without wrapping
package clk_div_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1
    } mon_state_e;

    function automatic int unsigned cnt_width(input int unsigned max_ratio);
        return $clog2(max_ratio + 2);
    endfunction

endpackage

// File: rtl/clk_div_edge_det.sv
// clk_div_edge_det: registers the divided clock and flags its edges.
//   clk    in  : source clock
//   resetn in  : synchronous reset, active low (registered copy resets to 0)
//   div_in in  : divided clock, synchronous to clk
//   rise   out : div_in high while its registered copy is low
//   fall   out : div_in low while its registered copy is high
//                (only present with CLK_DIV_MONITOR_DUTY_CHECK_EN)
module clk_div_edge_det (
    input  logic clk,
    input  logic resetn,
    input  logic div_in,
    output logic rise
`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
   ,output logic fall
`endif
);

    logic div_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_q <= 1'b0;
        end else begin
            div_q <= div_in;
        end
    end

    // div_q resets low, so a div_in already high right after reset is a rise.
    assign rise = div_in & ~div_q;
`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
    assign fall = ~div_in & div_q;
`endif

endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures the period of a divided clock in clk cycles and
// checks it against a programmed ratio.
//   clk            in  : source clock (same clock as the divider)
//   resetn         in  : synchronous reset, active low
//   div_in         in  : divided clock under test, synchronous to clk
//   expected_ratio in  : expected period in clk cycles (legal 2..MAX_RATIO)
//   period         out : last measured period
//   period_valid   out : one-cycle pulse when period updates
//   locked         out : high after LOCK_COUNT consecutive matching periods
//   mismatch       out : one-cycle pulse when a period differs from expected_ratio
//   timeout        out : sticky, no rise within MAX_RATIO+1 cycles while measuring
//   duty_err       out : one-cycle pulse on a bad high/low split
//                        (only with CLK_DIV_MONITOR_DUTY_CHECK_EN)
// Optional macro CLK_DIV_MONITOR_DUTY_CHECK_EN adds the duty-cycle check.
module clk_div_monitor
    import clk_div_monitor_pkg::*;
#(
    parameter  int unsigned MAX_RATIO  = 16,
    parameter  int unsigned LOCK_COUNT = 3,
    localparam int unsigned CNT_W      = cnt_width(MAX_RATIO)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_in,
    input  logic [CNT_W-1:0] expected_ratio,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             mismatch,
    output logic             timeout
`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
   ,output logic             duty_err
`endif
);

    localparam int unsigned      STREAK_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(MAX_RATIO + 1);
    localparam logic [CNT_W-1:0] MAX_R    = CNT_W'(MAX_RATIO);
    localparam logic [STREAK_W-1:0] LOCK_S = STREAK_W'(LOCK_COUNT);

    mon_state_e          state, state_next;
    logic                rise;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    exp_q;
    logic [STREAK_W-1:0] streak, streak_inc;
    logic                period_evt, timeout_evt;
    logic                ratio_ok, ratio_match, period_ok, exp_changed;

`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
    logic             fall;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W:0]   twice_h, per_x;
    logic             duty_ok;
`endif

    clk_div_edge_det u_edge (
        .clk    (clk),
        .resetn (resetn),
        .div_in (div_in),
        .rise   (rise)
`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
       ,.fall   (fall)
`endif
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        period_evt  = 1'b0;
        timeout_evt = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                // A rise on the timeout cycle still counts as a period.
                if (rise) begin
                    period_evt = 1'b1;
                end else if (cnt == TO_CNT) begin
                    timeout_evt = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ratio_ok    = (expected_ratio >= CNT_W'(2)) && (expected_ratio <= MAX_R);
        ratio_match = ratio_ok && (cnt == expected_ratio);
        exp_changed = (expected_ratio != exp_q);
        streak_inc  = (streak >= LOCK_S) ? LOCK_S : streak + STREAK_W'(1);
`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
        twice_h = {hcnt, 1'b0};
        per_x   = {1'b0, cnt};
        duty_ok = cnt[0] ? ((twice_h == per_x + (CNT_W+1)'(1)) ||
                            (twice_h == per_x - (CNT_W+1)'(1)))
                         : (twice_h == per_x);
        period_ok = ratio_match && duty_ok;
`else
        period_ok = ratio_match;
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt          <= '0;
            exp_q        <= '0;
            streak       <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            mismatch     <= 1'b0;
            timeout      <= 1'b0;
`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
            hcnt         <= '0;
            duty_err     <= 1'b0;
`endif
        end else begin
            exp_q        <= expected_ratio;
            period_valid <= 1'b0;
            mismatch     <= 1'b0;
`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
            duty_err     <= 1'b0;
            // cnt equals the cycles since the rise, so at the fall it is the
            // high-phase length; it holds until the next rise compares it.
            if (fall) begin
                hcnt <= cnt;
            end
`endif
            if (rise) begin
                cnt <= CNT_W'(1);
            end else if (state == MEASURE && !timeout_evt) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (period_evt) begin
                period       <= cnt;
                period_valid <= 1'b1;
                mismatch     <= !ratio_match;
`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
                duty_err     <= !duty_ok;
`endif
                if (period_ok) begin
                    streak <= streak_inc;
                    locked <= (streak_inc == LOCK_S);
                end else begin
                    streak <= '0;
                    locked <= 1'b0;
                end
            end

            if (timeout_evt) begin
                timeout <= 1'b1;
                streak  <= '0;
                locked  <= 1'b0;
            end

            // A ratio change overrides any streak progress made this cycle.
            if (exp_changed) begin
                streak <= '0;
                locked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
module tb_clk_div_monitor;

    localparam int MAXR  = 16;
    localparam int LOCKN = 3;
    localparam int W     = 5;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         div_in = 1'b0;
    logic [W-1:0] expected_ratio = W'(2);
    logic [W-1:0] period;
    logic         period_valid, locked, mismatch, timeout;
`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
    logic         duty_err;
`else
    logic         duty_err;
    assign duty_err = 1'b0;
`endif

    always #5 clk = ~clk;

    clk_div_monitor #(.MAX_RATIO(MAXR), .LOCK_COUNT(LOCKN)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .div_in         (div_in),
        .expected_ratio (expected_ratio),
        .period         (period),
        .period_valid   (period_valid),
        .locked         (locked),
        .mismatch       (mismatch),
        .timeout        (timeout)
`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
       ,.duty_err       (duty_err)
`endif
    );

    typedef struct {
        int period;
        bit mism;
        bit derr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: tracks rise timestamps and high-sample counts.
    bit m_rst = 1'b1;
    bit m_prev, m_meas, m_locked, m_timeout;
    int m_k = 0, m_last, m_hi, m_streak, m_pexp;

    function automatic bit duty_bad(input int p, input int h);
        if (p % 2 == 0) return (2 * h != p);
        return (2 * h != p - 1) && (2 * h != p + 1);
    endfunction

    always @(posedge clk) begin
        bit   r;
        int   gap;
        bit   derr, match;
        exp_t e;
        m_k++;
        if (!resetn) begin
            m_prev = 0; m_meas = 0; m_locked = 0; m_timeout = 0;
            m_hi = 0; m_streak = 0; m_pexp = 0; m_last = 0;
        end else begin
            r   = div_in && !m_prev;
            gap = m_k - m_last;
            if (m_meas && r) begin
`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
                derr = duty_bad(gap, m_hi);
`else
                derr = 0;
`endif
                match = (expected_ratio >= 2) && (expected_ratio <= MAXR) &&
                        (gap == int'(expected_ratio));
                if (match && !derr) m_streak = (m_streak + 1 > LOCKN) ? LOCKN : m_streak + 1;
                else m_streak = 0;
                e.period = gap; e.mism = !match; e.derr = derr;
                sb.push_back(e);
                m_last = m_k;
            end else if (m_meas && gap == MAXR + 1) begin
                m_timeout = 1; m_meas = 0; m_streak = 0;
            end else if (!m_meas && r) begin
                m_meas = 1; m_last = m_k;
            end
            if (r) m_hi = 1;
            else if (div_in) m_hi++;
            if (int'(expected_ratio) != m_pexp) m_streak = 0;
            m_pexp   = int'(expected_ratio);
            m_locked = (m_streak >= LOCKN);
            m_prev   = div_in;
        end
        m_rst = !resetn;
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (m_rst) begin
            chk("reset_outputs", int'({period, period_valid, locked, mismatch, timeout, duty_err}), 0);
        end else begin
            if (period_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_period_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("period", int'(period), e.period);
                    chk("mismatch", int'(mismatch), int'(e.mism));
                    chk("duty_err", int'(duty_err), int'(e.derr));
                end
            end else begin
                chk("missing_period_valid", sb.size(), 0);
                chk("idle_pulses", int'({mismatch, duty_err}), 0);
                sb.delete();
            end
            chk("locked", int'(locked), int'(m_locked));
            chk("timeout", int'(timeout), int'(m_timeout));
        end
    end

    task automatic tick(input bit d);
        @(negedge clk);
        div_in = d;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        repeat (n) begin
            repeat (hi) tick(1'b1);
            repeat (lo) tick(1'b0);
        end
    endtask

    initial begin
        int hi, lo, n;
        resetn = 1'b0;
        repeat (3) tick(1'b0);
        resetn = 1'b1;

        // div2 locking, div6 against ratio 4
        expected_ratio = W'(2);
        wave(1, 1, 8);
        expected_ratio = W'(4);
        wave(3, 3, 5);

        // lock on div4, then stall into timeout and restart
        wave(2, 2, 5);
        repeat (20) tick(1'b0);
        wave(2, 2, 5);

        // reset mid-period, then relock
        tick(1'b1);
        resetn = 1'b0;
        tick(1'b0);
        tick(1'b0);
        resetn = 1'b1;
        wave(2, 2, 6);

        // ratio change while locked, then back
        expected_ratio = W'(6);
        wave(2, 2, 3);
        expected_ratio = W'(4);
        wave(2, 2, 5);

        // boundaries: max ratio, rise on the timeout cycle, illegal ratios
        expected_ratio = W'(16);
        wave(8, 8, 5);
        expected_ratio = W'(17);
        wave(9, 8, 4);
        expected_ratio = W'(1);
        wave(1, 1, 5);
        expected_ratio = W'(0);
        wave(1, 1, 3);

        // duty split on period 6
        expected_ratio = W'(6);
        wave(2, 4, 5);
        wave(3, 3, 5);
        wave(4, 3, 4);
        expected_ratio = W'(7);
        wave(4, 3, 4);

        // randomized patterns
        repeat (80) begin
            hi = $urandom_range(1, 9);
            lo = $urandom_range(1, 9);
            n  = $urandom_range(1, 6);
            if ($urandom_range(0, 3) == 0) expected_ratio = W'($urandom_range(0, 17));
            else expected_ratio = W'(hi + lo);
            if ($urandom_range(0, 19) == 0) begin
                resetn = 1'b0;
                tick(div_in);
                resetn = 1'b1;
            end
            wave(hi, lo, n);
        end

        repeat (3) tick(1'b0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
